// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM encoding and bit-period helper
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_e;
  function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter held at 0 while disabled, strobes bit_end_o on its last count
module uart_baud_gen #(
  parameter int CNT_MAX = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic bit_end_o
);
  localparam int W = CNT_MAX > 1 ? $clog2(CNT_MAX) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    bit_end_o = en_i && cnt_q == W'(CNT_MAX - 1);
    cnt_d = (!en_i || bit_end_o) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a one-entry holding register so frames can run back-to-back
module uart_tx import uart_pkg::*; #(
  parameter int UART_BPS = 9600,
  parameter int CLK_FREQ = 50_000_000,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx
);
  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  state_e state_q, state_d;
  logic [7:0] hold_q, shift_q;
  logic [2:0] idx_q;
  logic hold_full_q, par_q, stop_q, tx_q, tx_d;
  logic baud_en, bit_end, last_stop, accept, load;
  assign baud_en = state_q != IDLE;
  uart_baud_gen #(.CNT_MAX(BAUD_CNT_MAX)) u_baud (
    .clk(sys_clk),
    .rst(sys_rst),
    .en_i(baud_en),
    .bit_end_o(bit_end)
  );
  always_ff @(posedge sys_clk) state_q <= sys_rst ? IDLE : state_d;
  always_comb begin
    last_stop = bit_end && (STOP_BITS == 1 || stop_q);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = hold_full_q ? START : IDLE;
      START:   state_d = bit_end ? DATA : START;
      DATA:    state_d = (bit_end && idx_q == 3'd7) ? (PARITY != PARITY_NONE ? PAR : STOP) : DATA;
      PAR:     state_d = bit_end ? STOP : PAR;
      STOP:    state_d = last_stop ? (hold_full_q ? START : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tx_busy = state_q != IDLE;
    tx_ready = !hold_full_q;
    tx = tx_q;
    tx_d = state_q == START ? 1'b0 :
           state_q == DATA  ? shift_q[0] :
           state_q == PAR   ? (PARITY == PARITY_ODD ? ~par_q : par_q) : 1'b1;
  end
  // START is only entered from IDLE or the final stop bit, which is exactly when the held byte moves on
  assign load = state_d == START && state_q != START;
  assign accept = pi_flag && !hold_full_q;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hold_full_q <= 1'b0;
      hold_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      idx_q <= '0;
      stop_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      tx_q <= tx_d;
      hold_full_q <= accept || (hold_full_q && !load);
      if (accept) hold_q <= pi_data;
      if (load) begin
        shift_q <= hold_q;
        par_q <= ^hold_q;
      end else if (state_q == DATA && bit_end) shift_q <= shift_q >> 1;
      if (state_q == DATA && bit_end) idx_q <= idx_q + 3'd1;
      if (state_q == STOP && bit_end) stop_q <= !last_stop;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table, corner-sequence and random checks of three uart_tx variants against a frame-level model
module tb_uart_tx;
  localparam int B = 10;
  localparam int N = 3;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic pi_flag = 1'b0;
  logic [7:0] pi_data = '0;
  logic [N-1:0] tx_w, busy_w, ready_w;
  uart_tx #(.UART_BPS(100_000), .CLK_FREQ(1_000_000)) d0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data), .pi_flag(pi_flag),
    .tx_ready(ready_w[0]), .tx_busy(busy_w[0]), .tx(tx_w[0]));
  uart_tx #(.UART_BPS(100_000), .CLK_FREQ(1_000_000), .PARITY(1), .STOP_BITS(2)) d1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data), .pi_flag(pi_flag),
    .tx_ready(ready_w[1]), .tx_busy(busy_w[1]), .tx(tx_w[1]));
  uart_tx #(.UART_BPS(100_000), .CLK_FREQ(1_050_000), .PARITY(2), .STOP_BITS(1)) d2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data), .pi_flag(pi_flag),
    .tx_ready(ready_w[2]), .tx_busy(busy_w[2]), .tx(tx_w[2]));
  always #5 sys_clk = ~sys_clk;
  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
    logic par_odd;
    logic par_even;
  } vec_t;
  vec_t vecs [6];
  bit m_busy [N];
  bit m_hf [N];
  bit m_tx [N];
  logic [7:0] m_hold [N];
  logic [11:0] m_bits [N];
  int m_nb [N];
  int m_cyc [N];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  function automatic int par_of(int i);
    return i;
  endfunction
  function automatic int stop_of(int i);
    return i == 1 ? 2 : 1;
  endfunction
  // Frame-level model: a frame is a list of line bits, each lasting B clocks, seen on tx one clock late
  function automatic void model_step(int i);
    bit acc, loaded;
    acc = pi_flag && !m_hf[i];
    loaded = 1'b0;
    if (sys_rst) begin
      m_busy[i] = 1'b0;
      m_hf[i] = 1'b0;
      m_tx[i] = 1'b1;
      m_cyc[i] = 0;
      return;
    end
    m_tx[i] = m_busy[i] ? m_bits[i][m_cyc[i] / B] : 1'b1;
    if (m_busy[i]) begin
      m_cyc[i]++;
      if (m_cyc[i] == m_nb[i] * B) m_busy[i] = 1'b0;
    end
    if (!m_busy[i] && m_hf[i]) begin
      m_bits[i] = {3'b111, m_hold[i], 1'b0};
      if (par_of(i) != 0) m_bits[i][9] = par_of(i) == 1 ? ~^m_hold[i] : ^m_hold[i];
      m_nb[i] = 9 + (par_of(i) != 0 ? 1 : 0) + stop_of(i);
      m_busy[i] = 1'b1;
      m_cyc[i] = 0;
      loaded = 1'b1;
    end
    if (acc) begin
      m_hf[i] = 1'b1;
      m_hold[i] = pi_data;
    end else if (loaded) m_hf[i] = 1'b0;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge sys_clk);
    for (int i = 0; i < N; i++) model_step(i);
    cyc++;
    @(negedge sys_clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("model_tx%0d", i), 32'(tx_w[i]), 32'(m_tx[i]));
      check($sformatf("model_busy%0d", i), 32'(busy_w[i]), 32'(m_busy[i]));
      check($sformatf("model_ready%0d", i), 32'(ready_w[i]), 32'(!m_hf[i]));
    end
  endtask
  task automatic run_until(int t);
    while (cyc < t) tick();
  endtask
  task automatic wait_idle();
    for (int k = 0; k < 1000 && !(&ready_w && !(|busy_w)); k++) tick();
    check("idle_reached", 32'({ready_w, busy_w}), 32'(6'b111000));
  endtask
  task automatic send(input logic [7:0] d, output int t0);
    pi_data = d;
    pi_flag = 1'b1;
    tick();
    t0 = cyc;
    pi_flag = 1'b0;
    pi_data = 8'($urandom);
  endtask
  task automatic sample_frame(input int ts, output logic [9:0] bits);
    for (int k = 0; k < 10; k++) begin
      run_until(ts + 2 + k * B + B / 2);
      bits[k] = tx_w[0];
    end
  endtask
  task automatic check_reset_outputs(string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_tx%0d", tag, i), 32'(tx_w[i]), 32'(1));
      check($sformatf("%s_busy%0d", tag, i), 32'(busy_w[i]), 32'(0));
      check($sformatf("%s_ready%0d", tag, i), 32'(ready_w[i]), 32'(1));
    end
  endtask
  initial begin
    logic [9:0] got;
    int t0, t1;
    vecs[0] = '{8'h35, 10'b1001101010, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 10'b1000000000, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b1, 1'b0};
    vecs[3] = '{8'hA5, 10'b1101001010, 1'b1, 1'b0};
    vecs[4] = '{8'h01, 10'b1000000010, 1'b0, 1'b1};
    vecs[5] = '{8'h07, 10'b1000001110, 1'b0, 1'b1};
    repeat (3) tick();
    check_reset_outputs("reset");
    sys_rst = 1'b0;
    tick();
    foreach (vecs[v]) begin
      wait_idle();
      send(vecs[v].data, t0);
      sample_frame(t0, got);
      check($sformatf("line_%02h", vecs[v].data), 32'(got), 32'(vecs[v].line));
      check($sformatf("par_odd_%02h", vecs[v].data), 32'(tx_w[1]), 32'(vecs[v].par_odd));
      check($sformatf("par_even_%02h", vecs[v].data), 32'(tx_w[2]), 32'(vecs[v].par_even));
      run_until(t0 + 2 + 10 * B + B / 2);
      check("stop1_d1", 32'(tx_w[1]), 32'(1));
      run_until(t0 + 2 + 11 * B + B / 2);
      check("stop2_d1", 32'(tx_w[1]), 32'(1));
      check("stop2_busy_d1", 32'(busy_w[1]), 32'(1));
      check("done_busy_d0", 32'(busy_w[0]), 32'(0));
    end
    wait_idle();
    send(8'h0E, t0);
    run_until(t0 + 20);
    check("ready_while_busy", 32'(ready_w[0]), 32'(1));
    send(8'h0C, t1);
    check("ready_after_queue", 32'(ready_w[0]), 32'(0));
    run_until(t0 + 1 + 10 * B);
    check("b2b_last_stop", 32'(tx_w[0]), 32'(1));
    tick();
    check("b2b_start", 32'(tx_w[0]), 32'(0));
    sample_frame(t0 + 10 * B, got);
    check("b2b_line", 32'(got), 32'({1'b1, 8'h0C, 1'b0}));
    wait_idle();
    send(8'h5A, t0);
    run_until(t0 + 15);
    send(8'h3C, t1);
    check("hold_full", 32'(ready_w[0]), 32'(0));
    send(8'hAA, t1);
    check("drop_keeps_full", 32'(ready_w[0]), 32'(0));
    sample_frame(t0 + 10 * B, got);
    check("held_line", 32'(got), 32'({1'b1, 8'h3C, 1'b0}));
    run_until(t0 + 20 * B + 5);
    check("no_third_frame", 32'(busy_w[0]), 32'(0));
    wait_idle();
    send(8'h96, t0);
    run_until(t0 + 2 + 3 * B + 3);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check_reset_outputs("midrst");
    send(8'hC3, t0);
    sample_frame(t0, got);
    check("after_rst_line", 32'(got), 32'({1'b1, 8'hC3, 1'b0}));
    for (int k = 0; k < 4000; k++) begin
      pi_flag = $urandom_range(0, 19) == 0;
      pi_data = 8'($urandom);
      sys_rst = $urandom_range(0, 999) == 0;
      tick();
    end
    sys_rst = 1'b0;
    pi_flag = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serialises 8-bit bytes onto the tx line. Frame format: LSB first, one start bit, 8 data bits, optional parity bit, 1 or 2 stop bits. It is the transmit-side counterpart of uart_rx and runs on the same sys_clk. A one-entry holding register lets the upstream logic queue the next byte while the current frame is still shifting out, so frames can run back-to-back.

Parameters:
UART_BPS, 9600, baud rate in bit/s
CLK_FREQ, 50_000_000, sys_clk frequency in Hz
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
sys_clk  input  1  system clock; all logic is on the rising edge
sys_rst  input  1  synchronous reset, active-high
pi_data  input  8  byte to transmit
pi_flag  input  1  one-cycle strobe: pi_data is valid this cycle
tx_ready output 1  high = holding register empty, so pi_flag will be accepted
tx_busy  output 1  high while a frame is on the line
tx       output 1  serial output, idles high

Behaviour:
- Interface: one clock (sys_clk); reset sys_rst is synchronous and active-high.
- Bit period: BAUD_CNT_MAX = CLK_FREQ/UART_BPS clocks, integer division. Default is 5208.
- Baud counter: counts 0..BAUD_CNT_MAX-1, then wraps. It is held at 0 in IDLE. A bit boundary occurs at count BAUD_CNT_MAX-1.
- Reset values: tx=1, tx_busy=0, tx_ready=1; holding register empty; FSM in IDLE; counters 0. Reset mid-frame aborts the frame. tx returns high on the next clock and the held byte is discarded.
- Accept rule: pi_flag=1 with tx_ready=1 captures pi_data into the holding register, and tx_ready drops the next cycle. pi_flag=1 with tx_ready=0 is ignored; the byte is dropped and held data is unchanged.
- Holding register: loaded into the shift register when leaving IDLE or at the end of the final stop bit. tx_ready returns to 1 on the cycle after that load.
- Same-cycle load and accept: if the holding register empties and pi_flag is accepted in the same cycle, the new byte is stored and tx_ready stays 0.
- FSM states and transitions:
  - IDLE: tx=1. If the holding register is full, go to START.
  - START: tx=0 for one bit period.
  - DATA: tx=shift[0]. Shift right each bit period. 3-bit bit index; leave after index 7.
  - PAR: present only if PARITY!=0. Odd: tx = ~^data. Even: tx = ^data. Parity is computed on the loaded byte.
  - STOP: tx=1 for STOP_BITS bit periods. At the end: if the holding register is full, go to START on the next cycle (no idle gap); else go to IDLE.
- tx is registered. Its first low cycle is exactly 2 clocks after an accepted pi_flag from IDLE: capture, then load, then tx.
- tx_busy is 1 in START, DATA, PAR and STOP; 0 in IDLE.
- Frame length: (1 + 8 + (PARITY!=0) + STOP_BITS) × BAUD_CNT_MAX clocks. Default is 52080.
- Inputs are not assumed to change only on bit boundaries; pi_flag may arrive on any cycle.

Decomposition:
- Shared package uart_pkg:
  - BAUD_CNT_MAX computation (function of CLK_FREQ, UART_BPS)
  - FSM state encoding localparams (IDLE, START, DATA, PAR, STOP)
  - PARITY_NONE / PARITY_ODD / PARITY_EVEN constants
  - This package is also used by uart_rx.
- One natural sub-module, uart_baud_gen: baud counter with an enable input and a one-cycle bit_end strobe output. It can be reused by uart_rx with a mid-bit strobe added.
- FSM, shift register and holding register stay in uart_tx.

Test Plan:
1. Reset, then pulse pi_flag with pi_data=8'h00 → tx low for 9×5208 clocks, high for the stop bit, then tx_busy=0 and tx_ready=1.
2. pi_data=8'h35, defaults → sampling tx at bit centres gives 0,1,0,1,0,1,1,0,0,1 (start, LSB-first data, stop). Loop tx back into uart_rx → po_data=8'h35 and po_flag pulses once.
3. Send 8'h0E, then 8'h0C while the first frame is busy and tx_ready=1 → second start bit begins on the clock right after the first stop bit ends; no idle gap.
4. Fill the holding register while busy, then pulse pi_flag with 8'hAA while tx_ready=0 → 8'hAA never appears on tx; the held byte is sent intact.
5. PARITY=1, 8'h01 → parity bit 0; PARITY=2, 8'h01 → parity bit 1. STOP_BITS=2 → stop high for 2×5208 clocks.
6. Assert sys_rst for 1 cycle mid-DATA → tx=1, tx_busy=0, tx_ready=1 on the next clock; a new byte then transmits cleanly.
